pl_ifid_queue: RTL and testbench
================================

Name: pl_ifid_queue

Overview:
- Parametrised successor to the IF/ID pipeline stage: a DEPTH-entry fetch queue that decodes each instruction at push time and presents the decoded head entry to ID/EX.
- Uses a valid/ready handshake on both sides, so the stage can stall.
- Flushes on a taken branch from EX.
- Flags illegal opcodes and RNS-domain operand misuse.

Parameters:
- PROG_CTR_WID, 10, width of program counter and branch target.
- DEPTH, 4, queue entries; power of 2, range 2..8.
- CNT_WID, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- if_valid  in  1  fetch offers an instruction.
- if_instr  in  16  instruction word from instr_mem.
- if_pc  in  PROG_CTR_WID  address of if_instr.
- if_ready  out  1  queue can accept a word: count != DEPTH.
- branch_taken_EX  in  1  flush request.
- id_ready  in  1  downstream accepts the head entry.
- id_valid  out  1  head entry is valid: count != 0.
- id_pc  out  PROG_CTR_WID  PC of the head entry.
- id_opcode  out  5  head instr[15:11].
- id_rd  out  3  instr[10:8]; forced to 0 for RSTORE.
- id_rs1  out  4  instr[3:0]; bit 3 = RNS domain flag.
- id_rs2  out  4  instr[7:4]; bit 3 = RNS domain flag.
- id_rs3  out  3  instr[10:8] for RSTORE, else 0.
- id_imm  out  8  instr[7:0].
- id_branch_tgt  out  PROG_CTR_WID  instr[9:0], zero-extended or truncated to PROG_CTR_WID; 0 for non-jumps.
- id_ctrl  out  24  decoded control vector (bit list below).
- id_illegal  out  1  opcode > 5'b10110.
- id_domain_err  out  1  (rs1[3] | rs2[3]) & ~rns on a legal, non-jump, non-LDI opcode.
- count  out  CNT_WID  current occupancy.

Behaviour:
- id_ctrl bit order, [0] upward:
  - add, and, or, not, andb, orb, notb, cin, op2c, jmp, cmp, shl,
  - lgcl, store, load, wr, jgt, jlt, jeq, jc, ujmp, ldi, mul, rns.
- Opcode decode (all other bits 0):
  - 00000 NOP: none.
  - 00001 ADD: add, wr.
  - 00010 SUB: add, cin, op2c, wr.
  - 00011 AND: and, lgcl, wr.
  - 00100 OR: or, lgcl, wr.
  - 00101 NOT: not, lgcl, wr.
  - 00110 SHL: shl, wr.
  - 00111 JMP: jmp, ujmp.
  - 01000 RLOAD: load, wr.
  - 01001 RSTORE: store.
  - 01010 ANDBIT: andb, lgcl, wr.
  - 01011 ORBIT: orb, lgcl, wr.
  - 01100 NOTBIT: notb, lgcl, wr.
  - 01101 CMP: add, cmp, cin, op2c.
  - 01110 JGT: jmp, jgt.
  - 01111 JLT: jmp, jlt.
  - 10000 JEQ: jmp, jeq.
  - 10001 JC: jmp, jc.
  - 10010 LDI: ldi, wr.
  - 10011 ADDMD: rns, add, wr.
  - 10100 SUBMD: rns, add, op2c, wr.
  - 10101 MULMD: rns, mul, wr.
  - 10110 RECNST: rns, wr.
  - 10111..11111: all 0, id_illegal=1.
- Decode is combinational on if_instr; the decoded fields are written into the entry on push.
- Push = if_valid & if_ready. Pop = id_valid & id_ready.
- Entries leave in FIFO order.
- Push and pop in the same cycle: count unchanged, pointers both advance.
- Latency: a word pushed at edge N appears on id_* after edge N when the queue was empty. There is no same-cycle bypass.
- Full (count==DEPTH): if_ready=0; if_valid is ignored.
- Empty: id_valid=0, and all id_* data outputs are driven to 0.
- Read and write pointers wrap modulo DEPTH.
- Flush: branch_taken_EX=1 at an edge sets count, rd_ptr and wr_ptr to 0.
  - Flush has priority over push and pop in that cycle; both are discarded.
  - id_valid=0 from the next cycle onward.
  - if_ready is unaffected combinationally during the flush cycle.
- Reset (rst=0, any time, including mid-operation): pointers and count go to 0 immediately.
  - id_valid=0, if_ready=1, all id_* outputs 0.
  - Storage contents are don't-care.
  - Normal operation resumes at the first edge after rst returns to 1.
- id_illegal and id_domain_err are informational only. The entry is still delivered, and downstream treats it as a NOP.

Test Plan:
- Empty queue, push 16'h0923 (ADD r1, rs2=2, rs1=3), pc=5, id_ready=1:
  - Next cycle: id_valid=1, id_opcode=1, id_rd=1, id_rs2=2, id_rs1=3, id_ctrl=bits{0,15}, id_pc=5.
  - Following cycle: count=0.
- id_ready=0, push 16'h925A (LDI r2,0x5A), 16'h4B12 (RSTORE), 16'h3955 (JMP 0x155), 16'h0923 for DEPTH=4:
  - count=4, if_ready=0; a fifth push is ignored.
  - Raising id_ready pops in order: LDI imm=8'h5A ldi+wr; RSTORE rd=0 rs3=3 store; JMP tgt=10'h155 jmp+ujmp; ADD.
- Full queue, if_valid=1 and id_ready=1 for one cycle: one pop only, count 4→3, no push that cycle. Next cycle the push is accepted, count 3→3.
- Count=3 with branch_taken_EX=1 and push and pop all in the same cycle: count=0, id_valid=0 next cycle, the pushed word is never delivered.
- Push 16'hF800: id_illegal=1, id_ctrl=0.
- Push 16'h092B (ADD, rs1=4'hB): id_domain_err=1.
- Push 16'h99A9 (ADDMD): id_domain_err=0, rns=1.
- rst=0 asserted asynchronously mid-cycle with count=2: id_valid, count and all outputs drop to 0 immediately; if_ready=1.

Source files
------------

// File: rtl/pl_ifid_queue.sv
// pl_ifid_queue: IF/ID fetch queue. Instructions are decoded on the way in,
// so every entry already holds the decoded fields. The ID side sees the head
// entry, or all zeros when the queue is empty.
module pl_ifid_queue #(
  parameter int PROG_CTR_WID = 10,
  parameter int DEPTH        = 4,
  parameter int CNT_WID      = $clog2(DEPTH+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_valid,
  input  logic [15:0]             if_instr,
  input  logic [PROG_CTR_WID-1:0] if_pc,
  output logic                    if_ready,
  input  logic                    branch_taken_EX,
  input  logic                    id_ready,
  output logic                    id_valid,
  output logic [PROG_CTR_WID-1:0] id_pc,
  output logic [4:0]              id_opcode,
  output logic [2:0]              id_rd,
  output logic [3:0]              id_rs1,
  output logic [3:0]              id_rs2,
  output logic [2:0]              id_rs3,
  output logic [7:0]              id_imm,
  output logic [PROG_CTR_WID-1:0] id_branch_tgt,
  output logic [23:0]             id_ctrl,
  output logic                    id_illegal,
  output logic                    id_domain_err,
  output logic [CNT_WID-1:0]      count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // control vector bit positions
  localparam int C_ADD = 0,  C_AND = 1,  C_OR = 2,   C_NOT = 3,  C_ANDB = 4,  C_ORB = 5;
  localparam int C_NOTB = 6, C_CIN = 7,  C_OP2C = 8, C_JMP = 9,  C_CMP = 10,  C_SHL = 11;
  localparam int C_LGCL = 12, C_STORE = 13, C_LOAD = 14, C_WR = 15, C_JGT = 16, C_JLT = 17;
  localparam int C_JEQ = 18, C_JC = 19, C_UJMP = 20, C_LDI = 21, C_MUL = 22, C_RNS = 23;

  localparam logic [4:0] OP_RSTORE = 5'b01001;
  localparam logic [4:0] OP_LDI    = 5'b10010;
  localparam logic [4:0] OP_LAST   = 5'b10110;

  typedef struct packed {
    logic [PROG_CTR_WID-1:0] pc;
    logic [4:0]              opcode;
    logic [2:0]              rd;
    logic [3:0]              rs1;
    logic [3:0]              rs2;
    logic [2:0]              rs3;
    logic [7:0]              imm;
    logic [PROG_CTR_WID-1:0] tgt;
    logic [23:0]             ctrl;
    logic                    illegal;
    logic                    domain_err;
  } entry_t;

  entry_t             mem [DEPTH];
  entry_t             dec;
  entry_t             head;
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic               push, pop;

  assign if_ready = (count != CNT_WID'(DEPTH));
  assign id_valid = (count != '0);
  assign push     = if_valid & if_ready;
  assign pop      = id_valid & id_ready;

  // decode the incoming word into the entry format
  always_comb begin
    logic [4:0] op;
    op         = if_instr[15:11];
    dec        = '0;
    dec.pc     = if_pc;
    dec.opcode = op;
    dec.rd     = if_instr[10:8];
    dec.rs1    = if_instr[3:0];
    dec.rs2    = if_instr[7:4];
    dec.imm    = if_instr[7:0];
    case (op)
      5'b00001: begin dec.ctrl[C_ADD] = 1'b1; dec.ctrl[C_WR] = 1'b1; end
      5'b00010: begin dec.ctrl[C_ADD] = 1'b1; dec.ctrl[C_CIN] = 1'b1;
                      dec.ctrl[C_OP2C] = 1'b1; dec.ctrl[C_WR] = 1'b1; end
      5'b00011: begin dec.ctrl[C_AND] = 1'b1; dec.ctrl[C_LGCL] = 1'b1; dec.ctrl[C_WR] = 1'b1; end
      5'b00100: begin dec.ctrl[C_OR] = 1'b1; dec.ctrl[C_LGCL] = 1'b1; dec.ctrl[C_WR] = 1'b1; end
      5'b00101: begin dec.ctrl[C_NOT] = 1'b1; dec.ctrl[C_LGCL] = 1'b1; dec.ctrl[C_WR] = 1'b1; end
      5'b00110: begin dec.ctrl[C_SHL] = 1'b1; dec.ctrl[C_WR] = 1'b1; end
      5'b00111: begin dec.ctrl[C_JMP] = 1'b1; dec.ctrl[C_UJMP] = 1'b1; end
      5'b01000: begin dec.ctrl[C_LOAD] = 1'b1; dec.ctrl[C_WR] = 1'b1; end
      5'b01001: begin dec.ctrl[C_STORE] = 1'b1; end
      5'b01010: begin dec.ctrl[C_ANDB] = 1'b1; dec.ctrl[C_LGCL] = 1'b1; dec.ctrl[C_WR] = 1'b1; end
      5'b01011: begin dec.ctrl[C_ORB] = 1'b1; dec.ctrl[C_LGCL] = 1'b1; dec.ctrl[C_WR] = 1'b1; end
      5'b01100: begin dec.ctrl[C_NOTB] = 1'b1; dec.ctrl[C_LGCL] = 1'b1; dec.ctrl[C_WR] = 1'b1; end
      5'b01101: begin dec.ctrl[C_ADD] = 1'b1; dec.ctrl[C_CMP] = 1'b1;
                      dec.ctrl[C_CIN] = 1'b1; dec.ctrl[C_OP2C] = 1'b1; end
      5'b01110: begin dec.ctrl[C_JMP] = 1'b1; dec.ctrl[C_JGT] = 1'b1; end
      5'b01111: begin dec.ctrl[C_JMP] = 1'b1; dec.ctrl[C_JLT] = 1'b1; end
      5'b10000: begin dec.ctrl[C_JMP] = 1'b1; dec.ctrl[C_JEQ] = 1'b1; end
      5'b10001: begin dec.ctrl[C_JMP] = 1'b1; dec.ctrl[C_JC] = 1'b1; end
      5'b10010: begin dec.ctrl[C_LDI] = 1'b1; dec.ctrl[C_WR] = 1'b1; end
      5'b10011: begin dec.ctrl[C_RNS] = 1'b1; dec.ctrl[C_ADD] = 1'b1; dec.ctrl[C_WR] = 1'b1; end
      5'b10100: begin dec.ctrl[C_RNS] = 1'b1; dec.ctrl[C_ADD] = 1'b1;
                      dec.ctrl[C_OP2C] = 1'b1; dec.ctrl[C_WR] = 1'b1; end
      5'b10101: begin dec.ctrl[C_RNS] = 1'b1; dec.ctrl[C_MUL] = 1'b1; dec.ctrl[C_WR] = 1'b1; end
      5'b10110: begin dec.ctrl[C_RNS] = 1'b1; dec.ctrl[C_WR] = 1'b1; end
      default:  dec.ctrl = '0;
    endcase
    // RSTORE names its source register in the rd slot; it writes nothing
    if (op == OP_RSTORE) begin
      dec.rs3 = if_instr[10:8];
      dec.rd  = '0;
    end
    if (dec.ctrl[C_JMP])
      dec.tgt = PROG_CTR_WID'(if_instr[9:0]);
    dec.illegal    = (op > OP_LAST);
    dec.domain_err = (if_instr[3] | if_instr[7]) & ~dec.ctrl[C_RNS] & ~dec.illegal
                     & ~dec.ctrl[C_JMP] & (op != OP_LDI);
  end

  // storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= dec;
  end

  // pointers and occupancy; flush wins over push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (branch_taken_EX) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_WID'(1);
        2'b01:   count <= count - CNT_WID'(1);
        default: count <= count;
      endcase
    end
  end

  // head entry, zeroed while empty
  always_comb begin
    head = '0;
    if (id_valid)
      head = mem[rd_ptr];
  end

  assign id_pc         = head.pc;
  assign id_opcode     = head.opcode;
  assign id_rd         = head.rd;
  assign id_rs1        = head.rs1;
  assign id_rs2        = head.rs2;
  assign id_rs3        = head.rs3;
  assign id_imm        = head.imm;
  assign id_branch_tgt = head.tgt;
  assign id_ctrl       = head.ctrl;
  assign id_illegal    = head.illegal;
  assign id_domain_err = head.domain_err;

endmodule

// File: tb/tb_pl_ifid_queue.sv
// tb_pl_ifid_queue: directed steps followed by random traffic, all checked
// against a queue-based reference model of the fetch queue.
module tb_pl_ifid_queue;
  localparam int PW = 10;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          if_valid = 1'b0;
  logic [15:0]   if_instr = '0;
  logic [PW-1:0] if_pc = '0;
  logic          if_ready;
  logic          branch_taken_EX = 1'b0;
  logic          id_ready = 1'b0;
  logic          id_valid;
  logic [PW-1:0] id_pc;
  logic [4:0]    id_opcode;
  logic [2:0]    id_rd;
  logic [3:0]    id_rs1, id_rs2;
  logic [2:0]    id_rs3;
  logic [7:0]    id_imm;
  logic [PW-1:0] id_branch_tgt;
  logic [23:0]   id_ctrl;
  logic          id_illegal, id_domain_err;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_err = 0;
  logic [PW+15:0] q[$];   // {pc, instr} in FIFO order

  pl_ifid_queue #(.PROG_CTR_WID(PW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .branch_taken_EX(branch_taken_EX), .id_ready(id_ready),
    .id_valid(id_valid), .id_pc(id_pc), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs3(id_rs3), .id_imm(id_imm),
    .id_branch_tgt(id_branch_tgt), .id_ctrl(id_ctrl), .id_illegal(id_illegal),
    .id_domain_err(id_domain_err), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // control vector straight from the opcode table, one named bit at a time
  function automatic logic [23:0] ref_ctrl(input logic [4:0] op);
    logic [23:0] c;
    c = '0;
    case (op)
      1:  begin c[0] = 1; c[15] = 1; end
      2:  begin c[0] = 1; c[7] = 1; c[8] = 1; c[15] = 1; end
      3:  begin c[1] = 1; c[12] = 1; c[15] = 1; end
      4:  begin c[2] = 1; c[12] = 1; c[15] = 1; end
      5:  begin c[3] = 1; c[12] = 1; c[15] = 1; end
      6:  begin c[11] = 1; c[15] = 1; end
      7:  begin c[9] = 1; c[20] = 1; end
      8:  begin c[14] = 1; c[15] = 1; end
      9:  c[13] = 1;
      10: begin c[4] = 1; c[12] = 1; c[15] = 1; end
      11: begin c[5] = 1; c[12] = 1; c[15] = 1; end
      12: begin c[6] = 1; c[12] = 1; c[15] = 1; end
      13: begin c[0] = 1; c[10] = 1; c[7] = 1; c[8] = 1; end
      14: begin c[9] = 1; c[16] = 1; end
      15: begin c[9] = 1; c[17] = 1; end
      16: begin c[9] = 1; c[18] = 1; end
      17: begin c[9] = 1; c[19] = 1; end
      18: begin c[21] = 1; c[15] = 1; end
      19: begin c[23] = 1; c[0] = 1; c[15] = 1; end
      20: begin c[23] = 1; c[0] = 1; c[8] = 1; c[15] = 1; end
      21: begin c[23] = 1; c[22] = 1; c[15] = 1; end
      22: begin c[23] = 1; c[15] = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // compare every output against the model's head entry
  task automatic check_all();
    logic [15:0] ins;
    logic [PW-1:0] pc;
    logic [4:0] op;
    bit isj, rst_op, ldi, rns, ill, nonempty;
    nonempty = (q.size() != 0);
    chk("id_valid", id_valid, nonempty);
    chk("count", count, q.size());
    chk("if_ready", if_ready, q.size() != DEPTH);
    ins = '0; pc = '0;
    if (nonempty) begin
      ins = q[0][15:0];
      pc  = q[0][PW+15:16];
    end
    op     = ins[15:11];
    isj    = op inside {5'd7, 5'd14, 5'd15, 5'd16, 5'd17};
    rst_op = (op == 5'd9);
    ldi    = (op == 5'd18);
    rns    = op inside {[5'd19:5'd22]};
    ill    = (op > 5'd22);
    chk("id_pc", id_pc, pc);
    chk("id_opcode", id_opcode, op);
    chk("id_rd", id_rd, rst_op ? 3'd0 : ins[10:8]);
    chk("id_rs1", id_rs1, ins[3:0]);
    chk("id_rs2", id_rs2, ins[7:4]);
    chk("id_rs3", id_rs3, rst_op ? ins[10:8] : 3'd0);
    chk("id_imm", id_imm, ins[7:0]);
    chk("id_branch_tgt", id_branch_tgt, isj ? ins[9:0] : 10'd0);
    chk("id_ctrl", id_ctrl, ref_ctrl(op));
    chk("id_illegal", id_illegal, nonempty && ill);
    chk("id_domain_err", id_domain_err,
        nonempty && (ins[3] | ins[7]) && !rns && !ill && !isj && !ldi);
  endtask

  // check, clock one edge, then advance the model by the same rules
  task automatic tick();
    bit push, pop;
    check_all();
    push = if_valid && (q.size() < DEPTH);
    pop  = (q.size() > 0) && id_ready;
    @(posedge clk);
    #1;
    if (branch_taken_EX) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({if_pc, if_instr});
    end
  endtask

  task automatic drive(input bit v, input logic [15:0] ins, input logic [PW-1:0] pc, input bit rdy);
    if_valid = v; if_instr = ins; if_pc = pc; id_ready = rdy;
  endtask

  initial begin
    // reset state
    #2;
    check_all();
    chk("rst_if_ready", if_ready, 1'b1);
    #10 rst = 1'b1;

    // single ADD, visible the cycle after push, popped the cycle after that
    drive(1, 16'h0923, 10'd5, 1);
    tick();
    drive(0, 16'h0, 10'd0, 1);
    chk("add_valid", id_valid, 1'b1);
    chk("add_opcode", id_opcode, 5'd1);
    chk("add_rd", id_rd, 3'd1);
    chk("add_rs2", id_rs2, 4'd2);
    chk("add_rs1", id_rs1, 4'd3);
    chk("add_ctrl", id_ctrl, 24'h008001);
    chk("add_pc", id_pc, 10'd5);
    tick();
    chk("add_drained", count, 0);

    // fill with id_ready low, fifth push dropped
    drive(1, 16'h925A, 10'd10, 0); tick();
    drive(1, 16'h4B12, 10'd11, 0); tick();
    drive(1, 16'h3955, 10'd12, 0); tick();
    drive(1, 16'h0923, 10'd13, 0); tick();
    chk("full_count", count, 4);
    chk("full_ready", if_ready, 1'b0);
    drive(1, 16'hF800, 10'd14, 0); tick();
    chk("fifth_ignored", count, 4);
    drive(0, 16'h0, 10'd0, 1);
    chk("ldi_imm", id_imm, 8'h5A);
    chk("ldi_ctrl", id_ctrl, 24'h208000);
    tick();
    chk("rstore_rd", id_rd, 3'd0);
    chk("rstore_rs3", id_rs3, 3'd3);
    chk("rstore_ctrl", id_ctrl, 24'h002000);
    tick();
    chk("jmp_tgt", id_branch_tgt, 10'h155);
    chk("jmp_ctrl", id_ctrl, 24'h100200);
    tick();
    chk("last_add", id_opcode, 5'd1);
    tick();
    chk("drained", count, 0);

    // full queue with both sides active: pop only, then push+pop
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 16'($urandom), 10'($urandom), 0); tick();
    end
    drive(1, 16'h1111, 10'd20, 1); tick();
    chk("full_pop_only", count, 3);
    drive(1, 16'h2222, 10'd21, 1); tick();
    chk("push_pop_same", count, 3);

    // flush with push and pop in the same cycle
    drive(1, 16'h3333, 10'd22, 1);
    branch_taken_EX = 1'b1;
    tick();
    branch_taken_EX = 1'b0;
    drive(0, 16'h0, 10'd0, 1);
    chk("flush_count", count, 0);
    chk("flush_valid", id_valid, 1'b0);
    tick();
    chk("flush_no_deliver", id_valid, 1'b0);

    // illegal opcode
    drive(1, 16'hF800, 10'd30, 0); tick();
    chk("illegal_flag", id_illegal, 1'b1);
    chk("illegal_ctrl", id_ctrl, 24'h0);
    drive(0, 16'h0, 10'd0, 1); tick();

    // domain error cases
    drive(1, 16'h092B, 10'd31, 0); tick();
    chk("dom_err_add", id_domain_err, 1'b1);
    drive(0, 16'h0, 10'd0, 1); tick();
    drive(1, 16'h99A9, 10'd32, 0); tick();
    chk("dom_err_addmd", id_domain_err, 1'b0);
    chk("addmd_rns", id_ctrl[23], 1'b1);
    drive(0, 16'h0, 10'd0, 1); tick();

    // asynchronous reset mid-cycle with two entries
    drive(1, 16'h0A55, 10'd40, 0); tick();
    drive(1, 16'h1234, 10'd41, 0); tick();
    drive(0, 16'h0, 10'd0, 0);
    chk("pre_rst_count", count, 2);
    #3 rst = 1'b0;
    #1;
    q.delete();
    chk("arst_valid", id_valid, 1'b0);
    chk("arst_count", count, 0);
    chk("arst_ready", if_ready, 1'b1);
    chk("arst_opcode", id_opcode, 5'd0);
    chk("arst_ctrl", id_ctrl, 24'h0);
    chk("arst_pc", id_pc, 10'd0);
    #2 rst = 1'b1;

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 16'($urandom), 10'($urandom), 1'($urandom_range(0, 1)));
      branch_taken_EX = ($urandom_range(0, 15) == 0);
      tick();
    end
    branch_taken_EX = 1'b0;
    check_all();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
